// File: rtl/fifo_pkg.sv
// Shared defaults and data types for the sync_fifo block.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

  typedef logic [FIFO_WIDTH-1:0] data_t;
  // Pointer carries one extra wrap bit above the address bits.
  typedef logic [FIFO_PTR_W:0]   ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_intf.sv
// Handshake/data bundle between a FIFO producer/consumer and sync_fifo.
interface fifo_intf #(
  parameter int WIDTH = fifo_pkg::FIFO_WIDTH
) (
  input logic clk_i,
  input logic rst_i
);

  logic             wr_en_i;
  logic             rd_en_i;
  logic [WIDTH-1:0] wdata_i;
  logic [WIDTH-1:0] rdata_o;
  logic             empty_o;
  logic             full_o;
  logic             error_o;

  // Environment side: drives requests, observes status.
  modport master (
    input  clk_i, rst_i,
    output wr_en_i, rd_en_i, wdata_i,
    input  rdata_o, empty_o, full_o, error_o
  );

  // FIFO side.
  modport slave (
    input  wr_en_i, rd_en_i, wdata_i,
    output rdata_o, empty_o, full_o, error_o
  );

endinterface : fifo_intf

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// Storage words are never reset; only the read register clears.
module fifo_mem #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Storage write port; a same-edge read of the same word sees the old value.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value unless a read is accepted.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  // Read data register with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with empty/full status and illegal-access flag.
// Build option: define SYNC_FIFO_STICKY_ERROR_EN to make error_o sticky until
// reset instead of a one-cycle pulse.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter  int WIDTH = FIFO_WIDTH,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic      clk_i,
  input logic      rst_i,
  fifo_intf.slave  bus
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           error_q,  error_d;

  logic empty;
  logic full;
  logic wr_acc;
  logic rd_acc;
  logic illegal;

  // Status decodes straight from the registered pointers.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // A write into a full FIFO is allowed when a read frees the slot the same
  // cycle; a read of an empty FIFO is never bypassed from the write data.
  assign wr_acc  = bus.wr_en_i && (!full || bus.rd_en_i);
  assign rd_acc  = bus.rd_en_i && !empty;
  assign illegal = (bus.wr_en_i && full && !bus.rd_en_i) ||
                   (bus.rd_en_i && empty);

  // Next-state for pointers and the error flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
`ifdef SYNC_FIFO_STICKY_ERROR_EN
    error_d = error_q || illegal;
`else
    error_d = illegal;
`endif
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      error_q  <= error_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[PTR_W-1:0]),
    .wdata_i (bus.wdata_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[PTR_W-1:0]),
    .rdata_o (bus.rdata_o)
  );

  assign bus.empty_o = empty;
  assign bus.full_o  = full;
  assign bus.error_o = error_q;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a reference queue model feeds a
// scoreboard of expected read data; a short vector table covers the basic
// handshake cases and hand-written sequences cover fill/drain, overflow,
// underflow, wrap and mid-operation reset.
module tb_sync_fifo;

  localparam int W = 8;
  localparam int D = 16;

  logic clk;
  logic rst_n;

  fifo_intf #(.WIDTH(W)) bus (.clk_i(clk), .rst_i(rst_n));

  sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mq[$];      // reference FIFO contents
  logic [W-1:0] exq[$];     // scoreboard: expected read data, in order
  logic [W-1:0] last_rd;    // expected rdata_o when no read is accepted
  bit           sticky_m;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [W-1:0] d;
    bit           e_empty;
    bit           e_full;
    bit           e_err;
    logic [W-1:0] e_rdata;
  } vec_t;

  vec_t vec [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: update model, push expected read data, then
  // after the edge pop the scoreboard and compare all outputs.
  task automatic step(input bit wr, input bit rd, input logic [W-1:0] d);
    bit m_full, m_empty, e_err;
    @(negedge clk);
    bus.wr_en_i = wr;
    bus.rd_en_i = rd;
    bus.wdata_i = d;
    m_full  = (mq.size() == D);
    m_empty = (mq.size() == 0);
    e_err   = (wr && m_full && !rd) || (rd && m_empty);
    if (rd && !m_empty) exq.push_back(mq.pop_front());
    if (wr && (!m_full || rd)) mq.push_back(d);
    @(posedge clk);
    #1;
    if (exq.size() > 0) last_rd = exq.pop_front();
    chk("rdata", bus.rdata_o, last_rd);
    chk("empty", bus.empty_o, (mq.size() == 0));
    chk("full",  bus.full_o,  (mq.size() == D));
`ifdef SYNC_FIFO_STICKY_ERROR_EN
    sticky_m = sticky_m || e_err;
    chk("error", bus.error_o, sticky_m);
`else
    chk("error", bus.error_o, e_err);
`endif
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst_n = 1'b0;
      bus.wr_en_i = 1'($urandom_range(0, 1));
      bus.rd_en_i = 1'($urandom_range(0, 1));
      bus.wdata_i = W'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      chk("rst_empty", bus.empty_o, 1'b1);
      chk("rst_full",  bus.full_o,  1'b0);
      chk("rst_error", bus.error_o, 1'b0);
      chk("rst_rdata", bus.rdata_o, 8'h00);
    end
    mq.delete();
    exq.delete();
    last_rd  = '0;
    sticky_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.wdata_i = '0;
    last_rd  = '0;
    sticky_m = 1'b0;

    //          wr rd d      empty full err rdata
    vec[0] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};  // underflow
    vec[1] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00};  // first write
    vec[2] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11};  // both, mid
    vec[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22};  // drain
    vec[4] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h22};  // both on empty
    vec[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22};  // idle
    vec[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33};  // read 0x33

    do_reset();

    for (int i = 0; i < 7; i++) begin
      step(vec[i].wr, vec[i].rd, vec[i].d);
      chk($sformatf("vec%0d_rdata", i), bus.rdata_o, vec[i].e_rdata);
      chk($sformatf("vec%0d_empty", i), bus.empty_o, vec[i].e_empty);
      chk($sformatf("vec%0d_full",  i), bus.full_o,  vec[i].e_full);
`ifndef SYNC_FIFO_STICKY_ERROR_EN
      chk($sformatf("vec%0d_error", i), bus.error_o, vec[i].e_err);
`endif
    end

    // Fill 0x00..0x0F, then drain in order.
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(i));
    chk("fill_full", bus.full_o, 1'b1);
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_order", bus.rdata_o, W'(i));
    end
    chk("drain_empty", bus.empty_o, 1'b1);

    // Refill, then overflow, then full + both.
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(8'h40 + i));
    step(1'b1, 1'b0, 8'hAA);
    chk("ovf_err", bus.error_o, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h55);
    chk("full_both_rd", bus.rdata_o, 8'h40);
    chk("full_both_full", bus.full_o, 1'b1);
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, 8'h00);
      if (bus.rdata_o == 8'hAA) chk("no_aa", bus.rdata_o, 8'h00);
    end
    chk("last_is_55", bus.rdata_o, 8'h55);

    // Underflow keeps rdata.
    step(1'b0, 1'b1, 8'h00);
    chk("udf_err", bus.error_o, 1'b1);
    chk("udf_rdata", bus.rdata_o, 8'h55);
    step(1'b0, 1'b0, 8'h00);

    // Interleaved traffic crossing the pointer wrap.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i >= 2) && ($urandom_range(0, 3) != 0), W'($urandom_range(0, 255)));
    end
    while (mq.size() > 0) step(1'b0, 1'b1, 8'h00);

    // Mid-operation reset with 5 entries queued.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(8'hC0 + i));
    do_reset();
    chk("post_rst_empty", bus.empty_o, 1'b1);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_rd_rdata", bus.rdata_o, 8'h00);
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_fresh", bus.rdata_o, 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sync_fifo
